// File: rtl/eth_tx_framer.sv
// Ethernet II TX framer: preamble/SFD, MAC header, payload, zero pad, CRC-32 FCS, IFG.
// Optional 802.1Q tag insertion when ETH_TX_VLAN_EN is defined.
module eth_tx_framer #(
    parameter logic [47:0] DEST_MAC     = 48'h023528fbdd66,
    parameter logic [47:0] SRC_MAC      = 48'h702227acdb65,
    parameter int          PREAMBLE_LEN = 7,
    parameter int          MIN_PAYLOAD  = 46,
    parameter int          MAX_PAYLOAD  = 1500,
    parameter int          IFG_BYTES    = 12
) (
    input  logic        eth_tx_clk,
    input  logic        rst_n,
    input  logic        eth_tx_en,
    input  logic [15:0] len_type,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
`ifdef ETH_TX_VLAN_EN
    input  logic [15:0] vlan_tci,
    input  logic        vlan_insert,
`endif
    output logic        s_tready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        pct_txed,
    output logic        underrun,
    output logic        oversize
);

    localparam logic [10:0] PRE_N = 11'(PREAMBLE_LEN);
    localparam logic [10:0] MIN_N = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_N = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_N = 11'(IFG_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC,
`ifdef ETH_TX_VLAN_EN
        S_VLAN,
`endif
        S_LEN, S_PAY, S_PAD, S_FCS, S_IFG, S_DRAIN
    } state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [31:0] crc;
    logic [15:0] len_q;
    logic [7:0]  hdr_byte;
    logic [31:0] crc_nxt;
    logic [31:0] fcs_sh;
    logic [10:0] min_pay;

    // Reflected CRC-32 (poly 0x04C11DB7), one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

`ifdef ETH_TX_VLAN_EN
    logic [15:0] tci_q;
    logic        vlan_q;
    assign min_pay = vlan_q ? (MIN_N - 11'd4) : MIN_N;
`else
    assign min_pay = MIN_N;
`endif

    assign s_tready = (state == S_PAY) || (state == S_DRAIN);
    assign busy     = (state != S_IDLE);
    assign fcs_sh   = (~crc) >> {cnt[1:0], 3'b000};
    assign crc_nxt  = crc32_byte(crc, hdr_byte);

    // Byte to send on the next edge for every CRC-covered state.
    always_comb begin
        hdr_byte = 8'h00;
        case (state)
            S_SFD: hdr_byte = mac_byte(DEST_MAC, 3'd0);
            S_DST: hdr_byte = (cnt < 11'd6) ? mac_byte(DEST_MAC, cnt[2:0]) : mac_byte(SRC_MAC, 3'd0);
            S_SRC: begin
                if (cnt < 11'd6)
                    hdr_byte = mac_byte(SRC_MAC, cnt[2:0]);
                else
`ifdef ETH_TX_VLAN_EN
                    hdr_byte = vlan_q ? 8'h81 : len_q[15:8];
`else
                    hdr_byte = len_q[15:8];
`endif
            end
`ifdef ETH_TX_VLAN_EN
            S_VLAN: begin
                case (cnt[2:0])
                    3'd1:    hdr_byte = 8'h00;
                    3'd2:    hdr_byte = tci_q[15:8];
                    3'd3:    hdr_byte = tci_q[7:0];
                    default: hdr_byte = len_q[15:8];
                endcase
            end
`endif
            S_LEN:   hdr_byte = len_q[7:0];
            S_PAY:   hdr_byte = s_tdata;
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            crc        <= 32'hFFFFFFFF;
            len_q      <= '0;
`ifdef ETH_TX_VLAN_EN
            tci_q      <= '0;
            vlan_q     <= 1'b0;
`endif
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            pct_txed   <= 1'b0;
            underrun   <= 1'b0;
            oversize   <= 1'b0;
        end else begin
            gmii_tx_er <= 1'b0;
            pct_txed   <= 1'b0;
            underrun   <= 1'b0;
            oversize   <= 1'b0;
            case (state)
                S_IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (eth_tx_en && s_tvalid) begin
                        state      <= S_PRE;
                        cnt        <= 11'd1;
                        crc        <= 32'hFFFFFFFF;
                        len_q      <= len_type;
`ifdef ETH_TX_VLAN_EN
                        tci_q      <= vlan_tci;
                        vlan_q     <= vlan_insert;
`endif
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= 8'h55;
                    end
                end
                S_PRE: begin
                    if (cnt < PRE_N) begin
                        gmii_txd <= 8'h55;
                        cnt      <= cnt + 11'd1;
                    end else begin
                        gmii_txd <= 8'hD5;
                        state    <= S_SFD;
                    end
                end
                S_SFD: begin
                    gmii_txd <= hdr_byte;
                    crc      <= crc_nxt;
                    state    <= S_DST;
                    cnt      <= 11'd1;
                end
                S_DST: begin
                    gmii_txd <= hdr_byte;
                    crc      <= crc_nxt;
                    if (cnt < 11'd6) begin
                        cnt <= cnt + 11'd1;
                    end else begin
                        state <= S_SRC;
                        cnt   <= 11'd1;
                    end
                end
                S_SRC: begin
                    gmii_txd <= hdr_byte;
                    crc      <= crc_nxt;
                    if (cnt < 11'd6) begin
                        cnt <= cnt + 11'd1;
                    end else begin
`ifdef ETH_TX_VLAN_EN
                        state <= vlan_q ? S_VLAN : S_LEN;
`else
                        state <= S_LEN;
`endif
                        cnt   <= 11'd1;
                    end
                end
`ifdef ETH_TX_VLAN_EN
                S_VLAN: begin
                    gmii_txd <= hdr_byte;
                    crc      <= crc_nxt;
                    if (cnt < 11'd4) cnt <= cnt + 11'd1;
                    else             state <= S_LEN;
                end
`endif
                S_LEN: begin
                    gmii_txd <= hdr_byte;
                    crc      <= crc_nxt;
                    state    <= S_PAY;
                    cnt      <= '0;
                end
                S_PAY: begin
                    if (!s_tvalid) begin
                        gmii_tx_er <= 1'b1;
                        gmii_txd   <= 8'h00;
                        underrun   <= 1'b1;
                        state      <= S_IFG;
                        cnt        <= '0;
                    end else if (cnt == MAX_N) begin
                        // Byte MAX+1 is swallowed; the frame is poisoned with TX_ER.
                        gmii_tx_er <= 1'b1;
                        gmii_txd   <= 8'h00;
                        oversize   <= 1'b1;
                        state      <= s_tlast ? S_IFG : S_DRAIN;
                        cnt        <= '0;
                    end else begin
                        gmii_txd <= hdr_byte;
                        crc      <= crc_nxt;
                        cnt      <= cnt + 11'd1;
                        if (s_tlast) begin
                            if ((cnt + 11'd1) < min_pay) begin
                                state <= S_PAD;
                                cnt   <= min_pay - (cnt + 11'd1);
                            end else begin
                                state <= S_FCS;
                                cnt   <= '0;
                            end
                        end
                    end
                end
                S_PAD: begin
                    gmii_txd <= hdr_byte;
                    crc      <= crc_nxt;
                    if (cnt == 11'd1) begin
                        state <= S_FCS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 11'd1;
                    end
                end
                S_FCS: begin
                    if (cnt < 11'd4) begin
                        gmii_txd <= fcs_sh[7:0];
                        pct_txed <= (cnt == 11'd3);
                        cnt      <= cnt + 11'd1;
                    end else begin
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= 8'h00;
                        state      <= S_IFG;
                        cnt        <= 11'd1;
                    end
                end
                S_IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (cnt >= IFG_N) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_DRAIN: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (s_tvalid && s_tlast) begin
                        state <= S_IFG;
                        cnt   <= 11'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: frame layout, padding, underrun, back-to-back IFG, oversize, reset.
module tb_eth_tx_framer;

    localparam int LOGN = 4096;

    logic        eth_tx_clk = 1'b0;
    logic        rst_n;
    logic        eth_tx_en;
    logic [15:0] len_type;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        pct_txed;
    logic        underrun;
    logic        oversize;

    eth_tx_framer dut (
        .eth_tx_clk (eth_tx_clk),
        .rst_n      (rst_n),
        .eth_tx_en  (eth_tx_en),
        .len_type   (len_type),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
`ifdef ETH_TX_VLAN_EN
        .vlan_tci   (16'h0000),
        .vlan_insert(1'b0),
`endif
        .s_tready   (s_tready),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .busy       (busy),
        .pct_txed   (pct_txed),
        .underrun   (underrun),
        .oversize   (oversize)
    );

    always #5 eth_tx_clk = ~eth_tx_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int tmo_cnt = 0;
    bit abort = 1'b0;

    logic [47:0] dmac = 48'h023528fbdd66;
    logic [47:0] smac = 48'h702227acdb65;
    logic [7:0]  pay   [2048];
    logic [7:0]  exp_b [2048];
    int          exp_n;

    // Per-cycle trace sampled mid-cycle.
    logic [7:0] l_txd [LOGN];
    bit l_en [LOGN], l_er [LOGN], l_pct [LOGN], l_und [LOGN], l_ovs [LOGN];
    bit l_rdy [LOGN], l_vld [LOGN], l_busy [LOGN];
    int log_n = 0;

    always @(negedge eth_tx_clk) begin
        if (log_n < LOGN) begin
            l_txd[log_n]  <= gmii_txd;
            l_en[log_n]   <= gmii_tx_en;
            l_er[log_n]   <= gmii_tx_er;
            l_pct[log_n]  <= pct_txed;
            l_und[log_n]  <= underrun;
            l_ovs[log_n]  <= oversize;
            l_rdy[log_n]  <= s_tready;
            l_vld[log_n]  <= s_tvalid;
            l_busy[log_n] <= busy;
            log_n         <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_b[exp_n] = b;
        exp_n++;
    endtask

    // MSB-first CRC fed LSB-first data bits, reflected at the end.
    function automatic logic [31:0] fcs_model(input int s, input int e);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = s; i < e; i++)
            for (int j = 0; j < 8; j++) begin
                fb = c[31] ^ exp_b[i][j];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        for (int j = 0; j < 32; j++) r[j] = c[31-j];
        return ~r;
    endfunction

    task automatic build_exp(input logic [15:0] lt, input int n, input bit full);
        logic [31:0] f;
        exp_n = 0;
        for (int i = 0; i < 7; i++) push(8'h55);
        push(8'hD5);
        for (int i = 0; i < 6; i++) push(dmac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) push(smac[47-8*i -: 8]);
        push(lt[15:8]);
        push(lt[7:0]);
        for (int i = 0; i < n; i++) push(pay[i]);
        if (full) begin
            while (exp_n < 22 + 46) push(8'h00);
            f = fcs_model(8, exp_n);
            push(f[7:0]); push(f[15:8]); push(f[23:16]); push(f[31:24]);
        end
    endtask

    task automatic stream(input int n, input bit with_last, input logic [15:0] lt);
        int t;
        bit r;
        len_type = lt;
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            s_tdata  = pay[i];
            s_tvalid = 1'b1;
            s_tlast  = with_last && (i == n - 1);
            t = 0;
            r = 1'b0;
            while (!r && t < 2000 && !abort) begin
                @(negedge eth_tx_clk);
                r = s_tready;
                @(posedge eth_tx_clk);
                t++;
            end
            if (!r && !abort) tmo_cnt++;
            if (!r) break;
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 4000) begin
            @(posedge eth_tx_clk);
            #1;
            t++;
        end
        if (busy) tmo_cnt++;
        repeat (2) begin
            @(posedge eth_tx_clk);
            #1;
        end
    endtask

    task automatic find_frame(input int base, input int k, output int st, output int len);
        int seen = 0;
        st  = -1;
        len = 0;
        for (int i = base; i < log_n; i++) begin
            if (l_en[i] && (i == base || !l_en[i-1])) begin
                if (seen == k) begin
                    st = i;
                    break;
                end
                seen++;
            end
        end
        if (st >= 0)
            while (st + len < log_n && l_en[st+len]) len++;
    endtask

    task automatic check_frame(input string tag, input int base, input int k, input int exp_len,
                               input int ncmp, output int st, output int len);
        find_frame(base, k, st, len);
        chk({tag, "_len"}, 32'(len), 32'(exp_len));
        if (st >= 0)
            for (int i = 0; i < ncmp && i < len; i++)
                chk($sformatf("%s_b%0d", tag, i), {24'd0, l_txd[st+i]}, {24'd0, exp_b[i]});
    endtask

    function automatic int tally(input int base, input int sel);
        int n = 0;
        for (int i = base; i < log_n; i++) begin
            case (sel)
                0:       if (l_pct[i]) n++;
                1:       if (l_er[i])  n++;
                2:       if (l_und[i]) n++;
                3:       if (l_ovs[i]) n++;
                default: if (l_vld[i] && l_rdy[i]) n++;
            endcase
        end
        return n;
    endfunction

    function automatic int ifg_len(input int last_idx);
        int n = 0;
        for (int i = last_idx + 1; i < log_n && l_busy[i]; i++) n++;
        return n;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_txd"},   32'(gmii_txd),   0);
        chk({tag, "_en"},    32'(gmii_tx_en), 0);
        chk({tag, "_er"},    32'(gmii_tx_er), 0);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_rdy"},   32'(s_tready),   0);
        chk({tag, "_pct"},   32'(pct_txed),   0);
        chk({tag, "_und"},   32'(underrun),   0);
        chk({tag, "_ovs"},   32'(oversize),   0);
    endtask

    initial begin
        int base, st, len, st2, len2, last_hs;
        rst_n     = 1'b0;
        eth_tx_en = 1'b0;
        len_type  = 16'h0000;
        s_tdata   = 8'h00;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        repeat (3) @(posedge eth_tx_clk);
        #1;
        chk_idle_outputs("reset");
        rst_n     = 1'b1;
        eth_tx_en = 1'b1;
        repeat (2) @(posedge eth_tx_clk);
        #1;

        // 46-byte payload, no padding
        for (int i = 0; i < 2048; i++) pay[i] = 8'((i * 7 + 3) & 255);
        base = log_n;
        stream(46, 1'b1, 16'h002E);
        wait_idle();
        build_exp(16'h002E, 46, 1'b1);
        check_frame("t1", base, 0, 72, 72, st, len);
        if (st >= 0) chk("t1_pct_last", 32'(l_pct[st+len-1]), 1);
        chk("t1_pct_cnt", 32'(tally(base, 0)), 1);
        chk("t1_er_cnt",  32'(tally(base, 1)), 0);
        if (st >= 0) chk("t1_ifg", 32'(ifg_len(st + len - 1)), 12);

        // 10-byte payload padded to minimum; eth_tx_en dropped mid-frame
        for (int i = 0; i < 2048; i++) pay[i] = 8'((255 - i * 13) & 255);
        base = log_n;
        fork
            stream(10, 1'b1, 16'h000A);
            begin
                repeat (6) @(posedge eth_tx_clk);
                #1 eth_tx_en = 1'b0;
            end
        join
        wait_idle();
        eth_tx_en = 1'b1;
        build_exp(16'h000A, 10, 1'b1);
        check_frame("t2", base, 0, 72, 72, st, len);
        chk("t2_pct_cnt", 32'(tally(base, 0)), 1);

        // Underrun after payload byte 20
        base = log_n;
        stream(20, 1'b0, 16'h0040);
        wait_idle();
        build_exp(16'h0040, 20, 1'b0);
        check_frame("t3", base, 0, 43, 42, st, len);
        if (st >= 0) begin
            chk("t3_err_er",  32'(l_er[st+len-1]), 1);
            chk("t3_err_txd", 32'(l_txd[st+len-1]), 0);
            chk("t3_ifg", 32'(ifg_len(st + len - 1)), 12);
        end
        chk("t3_und_cnt", 32'(tally(base, 2)), 1);
        chk("t3_er_cnt",  32'(tally(base, 1)), 1);
        chk("t3_pct_cnt", 32'(tally(base, 0)), 0);

        // Back-to-back frames with s_tvalid held high
        for (int i = 0; i < 2048; i++) pay[i] = 8'((i * 31 + 17) & 255);
        base = log_n;
        stream(50, 1'b1, 16'h0032);
        stream(12, 1'b1, 16'h000C);
        wait_idle();
        build_exp(16'h0032, 50, 1'b1);
        check_frame("t4a", base, 0, 76, 76, st, len);
        build_exp(16'h000C, 12, 1'b1);
        check_frame("t4b", base, 1, 72, 72, st2, len2);
        if (st >= 0 && st2 >= 0) chk("t4_gap", 32'(st2 - (st + len)), 13);
        chk("t4_pct_cnt", 32'(tally(base, 0)), 2);

        // Oversize: 1504 bytes, tlast on the last one
        for (int i = 0; i < 2048; i++) pay[i] = 8'((i * 5 + 1) & 255);
        base = log_n;
        stream(1504, 1'b1, 16'h0600);
        wait_idle();
        build_exp(16'h0600, 1500, 1'b0);
        check_frame("t5", base, 0, 1523, 1522, st, len);
        if (st >= 0) chk("t5_err_er", 32'(l_er[st+len-1]), 1);
        chk("t5_ovs_cnt", 32'(tally(base, 3)), 1);
        chk("t5_er_cnt",  32'(tally(base, 1)), 1);
        chk("t5_pct_cnt", 32'(tally(base, 0)), 0);
        chk("t5_hs_cnt",  32'(tally(base, 4)), 1504);
        last_hs = -1;
        for (int i = base; i < log_n; i++) if (l_vld[i] && l_rdy[i]) last_hs = i;
        if (last_hs >= 0) chk("t5_drain_en", 32'(l_en[last_hs]), 0);

        // Asynchronous reset in the middle of the payload
        for (int i = 0; i < 2048; i++) pay[i] = 8'((i * 3 + 100) & 255);
        fork
            stream(46, 1'b1, 16'h002E);
            begin
                repeat (35) @(posedge eth_tx_clk);
                #2;
                chk("t6_pre_busy", 32'(busy), 1);
                chk("t6_pre_rdy",  32'(s_tready), 1);
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk_idle_outputs("t6_rst");
            end
        join
        repeat (3) @(posedge eth_tx_clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        repeat (2) @(posedge eth_tx_clk);
        #1;
        base = log_n;
        stream(46, 1'b1, 16'h002E);
        wait_idle();
        build_exp(16'h002E, 46, 1'b1);
        check_frame("t6", base, 0, 72, 72, st, len);
        chk("t6_pct_cnt", 32'(tally(base, 0)), 1);

        chk("timeouts", 32'(tmo_cnt), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
